// File: rtl/adc_spi_seq.sv
// adc_spi_seq: serial configuration sequencer for the two octal ADCs.
// After a start pulse it pulses the ADC hard reset, waits, writes the
// built-in init table to both ADCs and raises conf_end. Afterwards it
// accepts single-register host writes with a req/ack handshake.
//
// Ports:
//   clk, rstb (sync, active low)
//   start                          - pulse: run reset + init sequence
//   req, req_sel, req_addr, req_data, ack - host write handshake
//   busy                           - high whenever not IDLE
//   conf_end                       - init table complete (level)
//   resetb, csb1, csb2, sclk, sdata - ADC pins (shared sclk/sdata)
//
// Optional: define ADC_SPI_TRANSFER_EN to follow every host frame with a
// device-update frame 24'h00FF01 to the same chip selects.
module adc_spi_seq #(
  parameter int CLK_DIV  = 2,
  parameter int CS_GAP   = 4,
  parameter int RST_LEN  = 16,
  parameter int WAIT_LEN = 1024,
  parameter int INIT_LEN = 3,
  parameter logic [INIT_LEN*24-1:0] INIT_TABLE = {24'h000018, 24'h001404, 24'h00FF01}
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        start,
  input  logic        req,
  input  logic [1:0]  req_sel,
  input  logic [12:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        ack,
  output logic        busy,
  output logic        conf_end,
  output logic        resetb,
  output logic        csb1,
  output logic        csb2,
  output logic        sclk,
  output logic        sdata
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST      = 3'd1;
  localparam logic [2:0] S_RST_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_SHIFT    = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam int CMAX0 = (RST_LEN > WAIT_LEN) ? RST_LEN : WAIT_LEN;
  localparam int CMAX  = (CMAX0 > CS_GAP) ? CMAX0 : CS_GAP;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int PW    = $clog2(2*CLK_DIV + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_LEN - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [PW-1:0] PH_RISE   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2*CLK_DIV - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(INIT_LEN - 1);

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ph;
  logic [4:0]    bc;
  logic [2:0]    idx;
  logic [23:0]   shreg;
  logic [1:0]    sel_r;
  logic          host;
`ifdef ADC_SPI_TRANSFER_EN
  logic          xfer;   // device-update frame already sent for this host write
`endif

  // Entry 0 sits in the top bits; shift entry i up to the top and take it.
  function automatic logic [23:0] tbl_entry(input logic [2:0] i);
    logic [INIT_LEN*24-1:0] t;
    t = INIT_TABLE << (24*int'(i));
    return t[INIT_LEN*24-1 -: 24];
  endfunction

  assign busy  = (state != S_IDLE);
  assign sdata = shreg[23];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ph       <= '0;
      bc       <= '0;
      idx      <= '0;
      shreg    <= '0;
      sel_r    <= '0;
      host     <= 1'b0;
      ack      <= 1'b0;
      conf_end <= 1'b0;
      resetb   <= 1'b1;
      csb1     <= 1'b1;
      csb2     <= 1'b1;
      sclk     <= 1'b0;
`ifdef ADC_SPI_TRANSFER_EN
      xfer     <= 1'b0;
`endif
    end else begin
      ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RST;
            conf_end <= 1'b0;
            resetb   <= 1'b0;
            cnt      <= '0;
          end else if (req && conf_end && !ack) begin
            // !ack: req is still high in the ack cycle, don't accept it twice
            ack   <= 1'b1;
            sel_r <= req_sel;
            host  <= 1'b1;
`ifdef ADC_SPI_TRANSFER_EN
            xfer  <= 1'b0;
`endif
            if (req_sel != 2'b00) begin
              state        <= S_LOAD;
              shreg        <= {3'b000, req_addr, req_data};
              {csb2, csb1} <= ~req_sel;
            end
          end
        end
        S_RST: begin
          if (cnt == RST_LAST) begin
            state  <= S_RST_WAIT;
            resetb <= 1'b1;
            cnt    <= '0;
          end else cnt <= cnt + 1'b1;
        end
        S_RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state        <= S_LOAD;
            idx          <= '0;
            host         <= 1'b0;
            sel_r        <= 2'b11;
            shreg        <= tbl_entry(3'd0);
            {csb2, csb1} <= 2'b00;
          end else cnt <= cnt + 1'b1;
        end
        S_LOAD: begin
          // csb already low and bit23 on sdata; this cycle is the setup slot
          state <= S_SHIFT;
          ph    <= '0;
          bc    <= '0;
        end
        S_SHIFT: begin
          ph <= ph + 1'b1;
          if (ph == PH_RISE) sclk <= 1'b1;
          if (ph == PH_LAST) begin
            sclk <= 1'b0;
            ph   <= '0;
            if (bc == 5'd23) begin
              state        <= S_GAP;
              cnt          <= '0;
              shreg        <= '0;
              {csb2, csb1} <= 2'b11;
            end else begin
              bc    <= bc + 1'b1;
              shreg <= {shreg[22:0], 1'b0};
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            if (!host) begin
              if (idx == IDX_LAST) begin
                conf_end <= 1'b1;
                state    <= S_IDLE;
              end else begin
                idx          <= idx + 1'b1;
                shreg        <= tbl_entry(idx + 3'd1);
                {csb2, csb1} <= ~sel_r;
                state        <= S_LOAD;
              end
            end else begin
`ifdef ADC_SPI_TRANSFER_EN
              if (!xfer) begin
                xfer         <= 1'b1;
                shreg        <= 24'h00FF01;
                {csb2, csb1} <= ~sel_r;
                state        <= S_LOAD;
              end else state <= S_IDLE;
`else
              state <= S_IDLE;
`endif
            end
          end else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
